// File: rtl/mux_scan_sequencer.sv
// Scans a 4-to-1 selector through codes 0..3, waits a settle time at each code,
// samples the selector output and publishes the assembled 4-bit word atomically.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_mode,
  input  logic       mux_m,
  output logic [1:0] sel,
  output logic [3:0] capture,
  output logic       capture_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] count, count_n;
  logic [3:0] shadow, shadow_n;
  logic [3:0] capture_n;
  logic [1:0] sel_n;
  logic       valid_n, busy_n, done_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 8'd0;
      shadow        <= 4'b0000;
      capture       <= 4'b0000;
      sel           <= 2'b00;
      capture_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      shadow        <= shadow_n;
      capture       <= capture_n;
      sel           <= sel_n;
      capture_valid <= valid_n;
      busy          <= busy_n;
      done          <= done_n;
    end
  end

  // The final sample writes bit 3 into the shadow copy and publishes the whole
  // word on that same edge, so capture never exposes a partially scanned value.
  always_comb begin
    state_n   = state;
    count_n   = count;
    shadow_n  = shadow;
    capture_n = capture;
    sel_n     = sel;
    valid_n   = capture_valid;
    busy_n    = busy;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sel_n   = 2'b00;
          count_n = RELOAD;
          busy_n  = 1'b1;
          state_n = SETTLE;
        end
      end

      SETTLE: begin
        if (count == 8'd0) begin
          state_n = SAMPLE;
        end else begin
          count_n = count - 8'd1;
        end
      end

      SAMPLE: begin
        shadow_n[sel] = mux_m;
        if (sel != 2'd3) begin
          sel_n   = sel + 2'd1;
          count_n = RELOAD;
          state_n = SETTLE;
        end else begin
          capture_n = shadow_n;
          valid_n   = 1'b1;
          done_n    = 1'b1;
          sel_n     = 2'b00;
          if (auto_mode) begin
            count_n = RELOAD;
            state_n = SETTLE;
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a default-settle instance and a SETTLE_CYCLES=1
// instance, each reading a modelled selector whose output is d_pat[sel].
module tb_mux_scan_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       auto_mode = 1'b0;
  logic [3:0] d_pat = 4'b0000;

  logic       mux0, mux1;
  logic [1:0] sel0, sel1;
  logic [3:0] cap0, cap1;
  logic       valid0, valid1, busy0, busy1, done0, done1;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_cap0 = 4'b0000;
  logic [3:0] exp_cap1 = 4'b0000;

  always #5 clock = ~clock;

  assign mux0 = d_pat[sel0];
  assign mux1 = d_pat[sel1];

  mux_scan_sequencer dut0 (
    .clock(clock), .reset(reset), .start(start), .auto_mode(auto_mode),
    .mux_m(mux0), .sel(sel0), .capture(cap0), .capture_valid(valid0),
    .busy(busy0), .done(done0)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .auto_mode(auto_mode),
    .mux_m(mux1), .sel(sel1), .capture(cap1), .capture_valid(valid1),
    .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scan model for the default instance: one code every 3 cycles, 12-cycle scan.
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; auto_mode = 1'b0; d_pat = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    exp_cap0 = 4'b0000; exp_cap1 = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({sel0, cap0, valid0, busy0, done0} !== 9'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle0 cycle %0d: got %b expected %b", i, {sel0, cap0, valid0, busy0, done0}, 9'b0);
      end
      total++;
      if ({sel1, cap1, valid1, busy1, done1} !== 9'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle1 cycle %0d: got %b expected %b", i, {sel1, cap1, valid1, busy1, done1}, 9'b0);
      end
    end
  endtask

  task automatic test_scan(input logic [3:0] d);
    d_pat = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      logic [1:0] es;
      logic [3:0] ec;
      es = (k < 12) ? 2'(k / 3) : 2'd0;
      ec = (k < 12) ? exp_cap0 : d;
      total++;
      if (sel0 !== es) begin
        bad++; $display("[TB] FAIL scan_sel edge %0d: got %0d expected %0d", k, sel0, es);
      end
      total++;
      if (busy0 !== (k < 12)) begin
        bad++; $display("[TB] FAIL scan_busy edge %0d: got %b expected %b", k, busy0, k < 12);
      end
      total++;
      if (done0 !== (k == 12)) begin
        bad++; $display("[TB] FAIL scan_done edge %0d: got %b expected %b", k, done0, k == 12);
      end
      total++;
      if (cap0 !== ec) begin
        bad++; $display("[TB] FAIL scan_capture edge %0d: got %b expected %b", k, cap0, ec);
      end
      if (k < 12) tick();
    end
    exp_cap0 = d;
    total++;
    if (valid0 !== 1'b1) begin
      bad++; $display("[TB] FAIL scan_valid: got %b expected 1", valid0);
    end
    tick();
    total++;
    if (done0 !== 1'b0) begin
      bad++; $display("[TB] FAIL scan_done_clear: got %b expected 0", done0);
    end
    repeat ($urandom_range(0, 3)) tick();
  endtask

  // Extra start pulses at edge 5 and coinciding with the final sample edge 12.
  task automatic test_start_while_busy();
    logic [3:0] d;
    int n_done;
    d = 4'($urandom_range(0, 15));
    d_pat = d;
    n_done = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      total++;
      if (busy0 !== (k < 12)) begin
        bad++; $display("[TB] FAIL busy_start_busy edge %0d: got %b expected %b", k, busy0, k < 12);
      end
      total++;
      if (done0 !== (k == 12)) begin
        bad++; $display("[TB] FAIL done_start_busy edge %0d: got %b expected %b", k, done0, k == 12);
      end
      if (done0 === 1'b1) n_done++;
      if (k == 4 || k == 11) start = 1'b1;
      if (k == 5 || k == 12) start = 1'b0;
      if (k < 24) tick();
    end
    exp_cap0 = d;
    total++;
    if (n_done != 1 || cap0 !== d) begin
      bad++; $display("[TB] FAIL start_busy_once: got done=%0d cap=%b expected done=1 cap=%b", n_done, cap0, d);
    end
  endtask

  task automatic test_auto();
    logic [3:0] ds [3];
    logic [3:0] old;
    ds[0] = 4'b1100;
    ds[1] = 4'($urandom_range(0, 15));
    ds[2] = 4'($urandom_range(0, 15));
    old = exp_cap0;
    d_pat = ds[0];
    auto_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      logic [1:0] es;
      logic [3:0] ec;
      logic ed;
      es = (k < 36) ? 2'((k % 12) / 3) : 2'd0;
      ec = (k < 12) ? old : ds[k / 12 - 1];
      ed = (k == 12 || k == 24 || k == 36);
      total++;
      if (sel0 !== es) begin
        bad++; $display("[TB] FAIL auto_sel edge %0d: got %0d expected %0d", k, sel0, es);
      end
      total++;
      if (busy0 !== (k < 36)) begin
        bad++; $display("[TB] FAIL auto_busy edge %0d: got %b expected %b", k, busy0, k < 36);
      end
      total++;
      if (done0 !== ed) begin
        bad++; $display("[TB] FAIL auto_done edge %0d: got %b expected %b", k, done0, ed);
      end
      total++;
      if (cap0 !== ec) begin
        bad++; $display("[TB] FAIL auto_capture edge %0d: got %b expected %b", k, cap0, ec);
      end
      if (k == 12) d_pat = ds[1];
      if (k == 24) d_pat = ds[2];
      if (k == 30) auto_mode = 1'b0;
      if (k < 36) tick();
    end
    exp_cap0 = ds[2];
    repeat (10) tick();
  endtask

  // Runs on the SETTLE_CYCLES=1 instance: one code every 2 cycles, 8-cycle scan.
  task automatic test_reset_mid_scan();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_pat = 4'($urandom_range(0, 15));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      total++;
      if (sel1 !== 2'(k / 2) || busy1 !== 1'b1) begin
        bad++; $display("[TB] FAIL mid_sel_busy edge %0d: got sel=%0d busy=%b expected sel=%0d busy=1", k, sel1, busy1, k / 2);
      end
      if (k < 4) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({sel1, cap1, valid1, busy1, done1} !== 9'b0) begin
      bad++; $display("[TB] FAIL mid_reset1: got %b expected %b", {sel1, cap1, valid1, busy1, done1}, 9'b0);
    end
    total++;
    if ({sel0, cap0, valid0, busy0, done0} !== 9'b0) begin
      bad++; $display("[TB] FAIL mid_reset0: got %b expected %b", {sel0, cap0, valid0, busy0, done0}, 9'b0);
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    total++;
    if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_beats_start: got busy1=%b busy0=%b expected 0 0", busy1, busy0);
    end
    exp_cap1 = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      logic [3:0] d;
      d = (n == 0) ? 4'b0011 : 4'($urandom_range(0, 15));
      d_pat = d;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k <= 8; k++) begin
        logic [1:0] es;
        logic [3:0] ec;
        es = (k < 8) ? 2'(k / 2) : 2'd0;
        ec = (k < 8) ? exp_cap1 : d;
        total++;
        if (sel1 !== es || busy1 !== (k < 8)) begin
          bad++; $display("[TB] FAIL fast_sel_busy edge %0d: got sel=%0d busy=%b expected sel=%0d busy=%b", k, sel1, busy1, es, k < 8);
        end
        total++;
        if (done1 !== (k == 8) || cap1 !== ec) begin
          bad++; $display("[TB] FAIL fast_done_cap edge %0d: got done=%b cap=%b expected done=%b cap=%b", k, done1, cap1, k == 8, ec);
        end
        if (k < 8) tick();
      end
      exp_cap1 = d;
      total++;
      if (valid1 !== 1'b1) begin
        bad++; $display("[TB] FAIL fast_valid: got %b expected 1", valid1);
      end
      repeat (14) tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan(4'b1010);
    test_scan(4'b0101);
    for (int i = 0; i < 4; i++) test_scan(4'($urandom_range(0, 15)));
    test_start_while_busy();
    test_scan(4'($urandom_range(0, 15)));
    test_auto();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
